// File: rtl/nave_control_input.sv
// Ship input controller: synchronize, debounce, resolve and rate-limit LEFT/RIGHT/FIRE buttons.
// Optional feature macro: NAVE_AUTOREPEAT_EN enables auto-repeat of held moves.
module nave_control_input #(
    parameter int DEB_CYCLES    = 4,
    parameter int REP_DELAY     = 16,
    parameter int REP_PERIOD    = 8,
    parameter int FIRE_COOLDOWN = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_L,
    input  logic BTN_R,
    input  logic BTN_F,
    output logic LEFT,
    output logic RIGHT,
    output logic M,
    output logic FIRE_RDY
);

    if (DEB_CYCLES < 1 || REP_DELAY < 2 || REP_PERIOD < 2 || FIRE_COOLDOWN < 1) begin : g_bad_params
        $error("nave_control_input: parameter out of range");
    end

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int CW = $clog2(FIRE_COOLDOWN + 1);

    typedef enum logic [1:0] {IDLE, HOLD_L, HOLD_R, BLOCK} state_t;

    // Bit 0 = left, bit 1 = right, bit 2 = fire.
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];
    logic          l, r;

    state_t        state_q, state_d;
    logic          left_q, left_d, right_q, right_d;
    logic          f_prev_q, f_rise;
    logic [CW-1:0] cd_q, cd_d;
    logic          m_q, m_d, rdy_q;

    assign raw = {BTN_F, BTN_R, BTN_L};
    assign l   = deb_q[0];
    assign r   = deb_q[1];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEB_CYCLES - 1)) deb_d[i] = ~deb_q[i];
                else                                 cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef NAVE_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW      = $clog2(REP_MAX);
    logic [RW-1:0] rep_q, rep_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rep_q <= '0;
        else      rep_q <= rep_d;
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (l && r)  state_d = BLOCK;
                else if (l)  state_d = HOLD_L;
                else if (r)  state_d = HOLD_R;
            end
            HOLD_L: begin
                if (!l)      state_d = IDLE;
                else if (r)  state_d = BLOCK;
            end
            HOLD_R: begin
                if (!r)      state_d = IDLE;
                else if (l)  state_d = BLOCK;
            end
            BLOCK: begin
                if (!l && !r) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses are computed here and registered, so outputs never see BTN_* combinationally.
    always_comb begin
        left_d  = 1'b0;
        right_d = 1'b0;
`ifdef NAVE_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (l && !r) begin
                    left_d = 1'b1;
`ifdef NAVE_AUTOREPEAT_EN
                    rep_d  = RW'(REP_DELAY - 1);
`endif
                end else if (r && !l) begin
                    right_d = 1'b1;
`ifdef NAVE_AUTOREPEAT_EN
                    rep_d   = RW'(REP_DELAY - 1);
`endif
                end
            end
`ifdef NAVE_AUTOREPEAT_EN
            HOLD_L: begin
                if (l && !r) begin
                    if (rep_q == '0) begin
                        left_d = 1'b1;
                        rep_d  = RW'(REP_PERIOD - 1);
                    end else begin
                        rep_d = rep_q - 1'b1;
                    end
                end
            end
            HOLD_R: begin
                if (r && !l) begin
                    if (rep_q == '0) begin
                        right_d = 1'b1;
                        rep_d   = RW'(REP_PERIOD - 1);
                    end else begin
                        rep_d = rep_q - 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // A rising edge landing while the cooldown is nonzero is dropped, never queued.
    assign f_rise = deb_q[2] & ~f_prev_q;

    always_comb begin
        m_d  = 1'b0;
        cd_d = cd_q;
        if (f_rise && cd_q == '0) begin
            m_d  = 1'b1;
            cd_d = CW'(FIRE_COOLDOWN);
        end else if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            f_prev_q <= 1'b0;
            cd_q     <= '0;
            m_q      <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            left_q   <= left_d;
            right_q  <= right_d;
            f_prev_q <= deb_q[2];
            cd_q     <= cd_d;
            m_q      <= m_d;
            rdy_q    <= (cd_d == '0);
        end
    end

    assign LEFT     = left_q;
    assign RIGHT    = right_q;
    assign M        = m_q;
    assign FIRE_RDY = rdy_q;

endmodule

// File: tb/tb_nave_control_input.sv
// Directed bench for nave_control_input; a second instance with an 11-cycle cooldown
// exercises the fire edge that lands exactly on the last cooldown cycle.
module tb_nave_control_input;

`ifdef NAVE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_l = 1'b0, btn_r = 1'b0, btn_f = 1'b0;
    logic left, right, m, fire_rdy;
    logic left2, right2, m2, fire_rdy2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nave_control_input dut (
        .CLK(clk), .RST(rst_n), .BTN_L(btn_l), .BTN_R(btn_r), .BTN_F(btn_f),
        .LEFT(left), .RIGHT(right), .M(m), .FIRE_RDY(fire_rdy)
    );

    nave_control_input #(.FIRE_COOLDOWN(11)) dut_c11 (
        .CLK(clk), .RST(rst_n), .BTN_L(btn_l), .BTN_R(btn_r), .BTN_F(btn_f),
        .LEFT(left2), .RIGHT(right2), .M(m2), .FIRE_RDY(fire_rdy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_l = 1'b0; btn_r = 1'b0; btn_f = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (left !== 1'b0)      begin errors++; $display("FAIL reset_left got %b expected 0", left); end
        checks++; if (right !== 1'b0)     begin errors++; $display("FAIL reset_right got %b expected 0", right); end
        checks++; if (m !== 1'b0)         begin errors++; $display("FAIL reset_m got %b expected 0", m); end
        checks++; if (fire_rdy !== 1'b1)  begin errors++; $display("FAIL reset_fire_rdy got %b expected 1", fire_rdy); end
        checks++; if (fire_rdy2 !== 1'b1) begin errors++; $display("FAIL reset_fire_rdy2 got %b expected 1", fire_rdy2); end
        rst_n = 1'b1;
    endtask

    task automatic test_left_hold();
        logic exp;
        btn_l = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp = (e == 7) || (AR && e >= 23 && ((e - 23) % 8) == 0);
            checks++; if (left !== exp)  begin errors++; $display("FAIL hold_left edge %0d got %b expected %b", e, left, exp); end
            checks++; if (right !== 1'b0) begin errors++; $display("FAIL hold_right edge %0d got %b expected 0", e, right); end
            checks++; if (m !== 1'b0)     begin errors++; $display("FAIL hold_m edge %0d got %b expected 0", e, m); end
        end
        btn_l = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++; if (left !== 1'b0) begin errors++; $display("FAIL release_left edge %0d got %b expected 0", e, left); end
        end
    endtask

    task automatic test_glitch();
        btn_r = 1'b1;
        repeat (3) tick();
        btn_r = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++; if (right !== 1'b0) begin errors++; $display("FAIL glitch_right edge %0d got %b expected 0", e, right); end
            checks++; if (left !== 1'b0)  begin errors++; $display("FAIL glitch_left edge %0d got %b expected 0", e, left); end
        end
        btn_r = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (right !== (e == 7)) begin errors++; $display("FAIL after_glitch_right edge %0d got %b expected %b", e, right, e == 7); end
        end
        settle();
    endtask

    task automatic test_block();
        btn_l = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (left !== (e == 7)) begin errors++; $display("FAIL block_first_left edge %0d got %b expected %b", e, left, e == 7); end
        end
        btn_r = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++; if (left !== 1'b0 || right !== 1'b0) begin errors++; $display("FAIL block_both_held edge %0d got L=%b R=%b expected 0 0", e, left, right); end
        end
        btn_r = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++; if (left !== 1'b0 || right !== 1'b0) begin errors++; $display("FAIL block_r_released edge %0d got L=%b R=%b expected 0 0", e, left, right); end
        end
        btn_l = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++; if (left !== 1'b0 || right !== 1'b0) begin errors++; $display("FAIL block_all_released edge %0d got L=%b R=%b expected 0 0", e, left, right); end
        end
        btn_r = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (right !== (e == 7)) begin errors++; $display("FAIL unblock_right edge %0d got %b expected %b", e, right, e == 7); end
            checks++; if (left !== 1'b0)      begin errors++; $display("FAIL unblock_left edge %0d got %b expected 0", e, left); end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        btn_l = 1'b1; btn_r = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++; if (left !== 1'b0 || right !== 1'b0) begin errors++; $display("FAIL simul_both edge %0d got L=%b R=%b expected 0 0", e, left, right); end
        end
        btn_l = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            checks++; if (left !== 1'b0 || right !== 1'b0) begin errors++; $display("FAIL simul_r_only edge %0d got L=%b R=%b expected 0 0", e, left, right); end
        end
        btn_r = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++; if (left !== 1'b0 || right !== 1'b0) begin errors++; $display("FAIL simul_released edge %0d got L=%b R=%b expected 0 0", e, left, right); end
        end
        btn_l = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (left !== (e == 7)) begin errors++; $display("FAIL simul_fresh_left edge %0d got %b expected %b", e, left, e == 7); end
        end
        settle();
    endtask

    task automatic test_fire();
        logic exp_m, exp_rdy, exp_m2, exp_rdy2;
        btn_f = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 8)  btn_f = 1'b0;
            if (e == 12) btn_f = 1'b1;
            tick();
            exp_m    = (e == 7) || (e == 18);
            exp_rdy  = !((e >= 7 && e <= 16) || (e >= 18 && e <= 27));
            exp_m2   = (e == 7);
            exp_rdy2 = !(e >= 7 && e <= 17);
            checks++; if (m !== exp_m)             begin errors++; $display("FAIL fire_m edge %0d got %b expected %b", e, m, exp_m); end
            checks++; if (fire_rdy !== exp_rdy)    begin errors++; $display("FAIL fire_rdy edge %0d got %b expected %b", e, fire_rdy, exp_rdy); end
            checks++; if (m2 !== exp_m2)           begin errors++; $display("FAIL fire_m_c11 edge %0d got %b expected %b", e, m2, exp_m2); end
            checks++; if (fire_rdy2 !== exp_rdy2)  begin errors++; $display("FAIL fire_rdy_c11 edge %0d got %b expected %b", e, fire_rdy2, exp_rdy2); end
            checks++; if (left !== 1'b0 || right !== 1'b0 || left2 !== 1'b0 || right2 !== 1'b0) begin
                errors++; $display("FAIL fire_no_move edge %0d got L=%b R=%b expected 0 0", e, left, right);
            end
        end
        btn_f = 1'b0;
        repeat (12) tick();
        btn_f = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (m !== (e == 7))  begin errors++; $display("FAIL refire_m edge %0d got %b expected %b", e, m, e == 7); end
            checks++; if (m2 !== (e == 7)) begin errors++; $display("FAIL refire_m_c11 edge %0d got %b expected %b", e, m2, e == 7); end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic exp;
        btn_l = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            if (e == 17) btn_f = 1'b1;
            tick();
            exp = (e == 7) || (AR && e == 23);
            checks++; if (left !== exp)   begin errors++; $display("FAIL mid_left edge %0d got %b expected %b", e, left, exp); end
            checks++; if (m !== (e == 23)) begin errors++; $display("FAIL mid_m edge %0d got %b expected %b", e, m, e == 23); end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (left !== 1'b0)      begin errors++; $display("FAIL abort_left got %b expected 0", left); end
        checks++; if (right !== 1'b0)     begin errors++; $display("FAIL abort_right got %b expected 0", right); end
        checks++; if (m !== 1'b0)         begin errors++; $display("FAIL abort_m got %b expected 0", m); end
        checks++; if (fire_rdy !== 1'b1)  begin errors++; $display("FAIL abort_fire_rdy got %b expected 1", fire_rdy); end
        checks++; if (fire_rdy2 !== 1'b1) begin errors++; $display("FAIL abort_fire_rdy_c11 got %b expected 1", fire_rdy2); end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (left !== (e == 7)) begin errors++; $display("FAIL post_reset_left edge %0d got %b expected %b", e, left, e == 7); end
            checks++; if (m !== (e == 7))    begin errors++; $display("FAIL post_reset_m edge %0d got %b expected %b", e, m, e == 7); end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_left_hold();
        test_glitch();
        test_block();
        test_simultaneous();
        test_fire();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
